// File: rtl/bw_frame_streamer.sv
// -----------------------------------------------------------------------------
// bw_frame_streamer
// Reads a finished grayscale frame out of the BW SRAM in raster order and emits
// it as a valid/ready pixel stream, replicating each 8-bit gray sample into
// {R,G,B}. A 2-entry skid FIFO absorbs the SRAM's one-cycle read latency and
// downstream back-pressure.
//
// Ports:
//   clk, rst            single rising-edge clock, synchronous active-high reset
//   start               one-cycle pulse; begins a readout when idle
//   max_x, max_y        last column / row index (inclusive), sampled on start
//   x_addr_bw,y_addr_bw BW SRAM address (zero while no read is issued)
//   ren_bw              BW SRAM read enable
//   rdat_bw             BW SRAM read data, valid the cycle after ren_bw
//   out_valid/out_ready output handshake
//   out_pixel           {gray, gray, gray}
//   out_eol, out_eof    last pixel of row / of frame
//   busy                high from accepted start until done falls
//   done                one-cycle pulse when the eof pixel has been taken
// -----------------------------------------------------------------------------
module bw_frame_streamer #(
   parameter int X_MAX       = 200,
   parameter int Y_MAX       = 200,
   parameter int PIXEL_DEPTH = 24
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic [$clog2(X_MAX)-1:0] max_x,
   input  logic [$clog2(Y_MAX)-1:0] max_y,
   output logic [$clog2(X_MAX):0]   x_addr_bw,
   output logic [$clog2(Y_MAX):0]   y_addr_bw,
   output logic                     ren_bw,
   input  logic [7:0]               rdat_bw,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [PIXEL_DEPTH-1:0]   out_pixel,
   output logic                     out_eol,
   output logic                     out_eof,
   output logic                     busy,
   output logic                     done
);

   localparam int XW = $clog2(X_MAX);
   localparam int YW = $clog2(Y_MAX);

   typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

   state_t          r_state;
   logic [XW-1:0]   r_max_x, r_rd_x;
   logic [YW-1:0]   r_max_y, r_rd_y;
   logic            r_busy, r_done;

   // Read in flight: SRAM data lands next cycle, flags travel alongside it.
   logic            r_inflight, r_infl_eol, r_infl_eof;

   // 2-entry skid FIFO.
   logic [7:0]      r_fifo_data [2];
   logic [1:0]      r_fifo_eol, r_fifo_eof;
   logic            r_wptr, r_rptr;
   logic [1:0]      r_count;

   logic            w_pop, w_issue, w_rd_eol, w_rd_eof;

   assign out_valid = (r_count != 2'd0);
   assign w_pop     = out_valid & out_ready;
   assign w_rd_eol  = (r_rd_x == r_max_x);
   assign w_rd_eof  = w_rd_eol && (r_rd_y == r_max_y);

   // Issue only if the read still has a slot when it lands: occupancy plus the
   // read already in flight, minus whatever leaves this cycle, must be below 2.
   assign w_issue = (r_state == S_READ) &&
                    (({1'b0, r_count} + {2'b00, r_inflight}) < (3'd2 + {2'b00, w_pop}));

   // NOTE: always_comb gives every output a default first so no path leaves a
   // value unassigned, which would otherwise infer a latch.
   always_comb begin
      ren_bw    = 1'b0;
      x_addr_bw = '0;
      y_addr_bw = '0;
      if (w_issue) begin
         ren_bw    = 1'b1;
         x_addr_bw = {1'b0, r_rd_x};
         y_addr_bw = {1'b0, r_rd_y};
      end
   end

   // Outputs are forced to zero while the FIFO is empty so stale storage never
   // shows up on the bus and reset values hold without resetting the storage.
   always_comb begin
      out_pixel = '0;
      out_eol   = 1'b0;
      out_eof   = 1'b0;
      if (out_valid) begin
         out_pixel = {3{r_fifo_data[r_rptr]}};
         out_eol   = r_fifo_eol[r_rptr];
         out_eof   = r_fifo_eof[r_rptr];
      end
   end

   assign busy = r_busy;
   assign done = r_done;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of the others, independent of block order.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_inflight <= 1'b0;
         r_infl_eol <= 1'b0;
         r_infl_eof <= 1'b0;
         r_wptr     <= 1'b0;
         r_rptr     <= 1'b0;
         r_count    <= 2'd0;
      end else begin
         r_inflight <= w_issue;
         r_infl_eol <= w_rd_eol;
         r_infl_eof <= w_rd_eof;
         if (r_inflight) r_wptr <= ~r_wptr;
         if (w_pop)      r_rptr <= ~r_rptr;
         r_count <= r_count + {1'b0, r_inflight} - {1'b0, w_pop};
      end
   end

   // NOTE: the FIFO storage has no reset; occupancy and pointers are reset and
   // the outputs are masked while empty, so stored contents never matter then.
   always_ff @(posedge clk) begin
      if (r_inflight && !rst) begin
         r_fifo_data[r_wptr] <= rdat_bw;
         r_fifo_eol[r_wptr]  <= r_infl_eol;
         r_fifo_eof[r_wptr]  <= r_infl_eof;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_max_x <= '0;
         r_max_y <= '0;
         r_rd_x  <= '0;
         r_rd_y  <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_max_x <= max_x;
                  r_max_y <= max_y;
                  r_rd_x  <= '0;
                  r_rd_y  <= '0;
                  r_busy  <= 1'b1;
                  r_state <= S_READ;
               end
            end
            S_READ: begin
               if (w_issue) begin
                  if (w_rd_eol) begin
                     r_rd_x <= '0;
                     r_rd_y <= r_rd_y + 1'b1;
                  end else begin
                     r_rd_x <= r_rd_x + 1'b1;
                  end
                  if (w_rd_eof) r_state <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               if (w_pop && out_eof) begin
                  r_done  <= 1'b1;
                  r_state <= S_DONE;
               end
            end
            S_DONE: begin
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // A capture into a full FIFO that is not draining this cycle would drop data.
   always_ff @(posedge clk) begin
      if (!rst) begin
         assert (!(r_inflight && (r_count == 2'd2) && !w_pop));
      end
   end

endmodule

// File: tb/tb_bw_frame_streamer.sv
// -----------------------------------------------------------------------------
// tb_bw_frame_streamer
// Self-checking bench: a registered-read SRAM model feeds the DUT, and a queue
// of expected pixels built in raster order from the SRAM contents is compared
// against every output handshake.
// -----------------------------------------------------------------------------
module tb_bw_frame_streamer;

   localparam int X_MAX = 200;
   localparam int Y_MAX = 200;
   localparam int XW    = $clog2(X_MAX);
   localparam int YW    = $clog2(Y_MAX);

   typedef struct packed {
      logic [23:0] pix;
      logic        eol;
      logic        eof;
   } pix_t;

   logic          clk = 1'b0;
   logic          rst, start, out_ready;
   logic [XW-1:0] max_x;
   logic [YW-1:0] max_y;
   logic [XW:0]   x_addr_bw;
   logic [YW:0]   y_addr_bw;
   logic          ren_bw;
   logic [7:0]    rdat_bw = 8'h00;
   logic          out_valid, out_eol, out_eof, busy, done;
   logic [23:0]   out_pixel;

   bw_frame_streamer #(.X_MAX(X_MAX), .Y_MAX(Y_MAX), .PIXEL_DEPTH(24)) dut (
      .clk(clk), .rst(rst), .start(start), .max_x(max_x), .max_y(max_y),
      .x_addr_bw(x_addr_bw), .y_addr_bw(y_addr_bw), .ren_bw(ren_bw),
      .rdat_bw(rdat_bw), .out_valid(out_valid), .out_ready(out_ready),
      .out_pixel(out_pixel), .out_eol(out_eol), .out_eof(out_eof),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   // SRAM model: one-cycle registered read.
   logic [7:0] sram [16][16];
   always @(posedge clk) begin
      if (ren_bw)
         rdat_bw <= (x_addr_bw < 16 && y_addr_bw < 16) ? sram[y_addr_bw[3:0]][x_addr_bw[3:0]] : 8'hEE;
   end

   pix_t        exp_q[$];
   int          vectors = 0, miscompares = 0;
   int          cyc = 0, t_start = 0;
   int          n_ren = 0, n_pop = 0, n_done = 0, n_pix = 0, fr_w = 1;
   int          eof_cyc = -100, first_valid_cyc = -1, done_cyc = -1;
   logic        prev_stall = 1'b0, prev_done = 1'b0, start_on_done = 1'b0;
   logic [23:0] prev_pix;
   logic        prev_eol, prev_eof;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_ren"},   ren_bw,    0);
      check({tag, "_xaddr"}, x_addr_bw, 0);
      check({tag, "_yaddr"}, y_addr_bw, 0);
      check({tag, "_valid"}, out_valid, 0);
      check({tag, "_pixel"}, out_pixel, 0);
      check({tag, "_eol"},   out_eol,   0);
      check({tag, "_eof"},   out_eof,   0);
      check({tag, "_busy"},  busy,      0);
      check({tag, "_done"},  done,      0);
   endtask

   function automatic logic ready_for(input int mode, input int k);
      if (mode == 1) return 1'($urandom_range(0, 1));
      if (mode == 2) return (k >= 20);
      return 1'b1;
   endfunction

   // One clock cycle, entered and left 1 time unit after a rising edge.
   task automatic tick(input logic rdy);
      pix_t e;
      out_ready = rdy;
      #1;
      if (prev_done) check("busy_after_done", busy, 0);
      if (busy) check("outstanding_le_3", (n_ren - n_pop) <= 3, 1);
      if (ren_bw) begin
         check("rd_x", x_addr_bw, n_ren % fr_w);
         check("rd_y", y_addr_bw, n_ren / fr_w);
         n_ren++;
      end
      if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (prev_stall) begin
         check("stall_valid", out_valid, 1);
         check("stall_pixel", out_pixel, prev_pix);
         check("stall_eol",   out_eol,   prev_eol);
         check("stall_eof",   out_eof,   prev_eof);
      end
      if (out_valid && out_ready) begin
         check("pixel_pending", exp_q.size() > 0, 1);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("pixel", out_pixel, e.pix);
            check("eol",   out_eol,   e.eol);
            check("eof",   out_eof,   e.eof);
         end
         n_pop++;
         if (out_eof) eof_cyc = cyc;
      end
      if (done) begin
         n_done++;
         done_cyc = cyc;
         check("done_after_eof", cyc - eof_cyc, 1);
         check("busy_at_done", busy, 1);
         if (start_on_done) start = 1'b1;
      end
      prev_done  = done;
      prev_stall = out_valid && !out_ready;
      prev_pix   = out_pixel;
      prev_eol   = out_eol;
      prev_eof   = out_eof;
      @(posedge clk);
      #1;
      start = 1'b0;
      cyc++;
   endtask

   task automatic setup_frame(input int mx, input int my);
      pix_t e;
      exp_q.delete();
      for (int y = 0; y <= my; y++) begin
         for (int x = 0; x <= mx; x++) begin
            e.pix = {3{sram[y][x]}};
            e.eol = (x == mx);
            e.eof = (x == mx) && (y == my);
            exp_q.push_back(e);
         end
      end
      n_pix = (mx + 1) * (my + 1);
      fr_w  = mx + 1;
      n_ren = 0; n_pop = 0; n_done = 0;
      first_valid_cyc = -1; done_cyc = -1; eof_cyc = -100;
      max_x = XW'(mx);
      max_y = YW'(my);
   endtask

   // rmode: 0 always ready, 1 random ready, 2 ready low for cycles T..T+19.
   task automatic run_frame(input int mx, input int my, input int rmode,
                            input int restart_at, input int budget);
      setup_frame(mx, my);
      start   = 1'b1;
      t_start = cyc;
      for (int k = 0; k < budget && n_done == 0; k++) begin
         if (k == restart_at) begin
            start = 1'b1;
            max_x = '1;
            max_y = '1;
         end
         tick(ready_for(rmode, k));
         if (k == 0) begin
            check("busy_t1", busy, 1);
            check("ren_t1",  ren_bw, 1);
         end
         if (rmode == 2 && k == 19) begin
            check("stall_reads", n_ren, 2);
            check("stall_hold_valid", out_valid, 1);
            check("stall_hold_pixel", out_pixel, {3{sram[0][0]}});
         end
      end
      check("done_seen",    n_done, 1);
      check("queue_empty",  exp_q.size(), 0);
      check("read_count",   n_ren, n_pix);
      repeat (3) tick(1'b1);
      check("single_done",  n_done, 1);
      check("no_extra_pix", n_pop, n_pix);
      check("no_extra_ren", n_ren, n_pix);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; start = 1'b0; out_ready = 1'b0; max_x = '0; max_y = '0;
      repeat (2) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      rst = 1'b0;

      // 4x3 ramp frame, full throughput.
      for (int y = 0; y < 16; y++)
         for (int x = 0; x < 16; x++)
            sram[y][x] = 8'(16 * y + x);
      run_frame(3, 2, 0, -1, 60);
      check("first_valid_t3", first_valid_cyc - t_start, 3);
      check("done_t15",       done_cyc - t_start, 15);

      // Same frame under random back-pressure.
      run_frame(3, 2, 1, -1, 300);

      // Ready held low for 20 cycles from the start pulse.
      run_frame(3, 2, 2, -1, 300);

      // Second start mid-frame with different limits must be ignored.
      run_frame(3, 2, 0, 5, 60);
      check("restart_done_t15", done_cyc - t_start, 15);

      // Single-pixel frame, and a start pulse on the done cycle.
      sram[0][0] = 8'hA5;
      start_on_done = 1'b1;
      run_frame(0, 0, 0, -1, 20);
      start_on_done = 1'b0;
      check("single_first_valid", first_valid_cyc - t_start, 3);
      check("single_done_t4",     done_cyc - t_start, 4);
      check("start_at_done_busy", busy, 0);

      // Reset after the fifth pixel, then a fresh full frame.
      for (int y = 0; y < 16; y++)
         for (int x = 0; x < 16; x++)
            sram[y][x] = 8'(16 * y + x);
      setup_frame(3, 2);
      start   = 1'b1;
      t_start = cyc;
      for (int k = 0; k < 100 && n_pop < 5; k++) tick(1'b1);
      check("five_popped", n_pop, 5);
      rst = 1'b1;
      out_ready = 1'b0;
      @(posedge clk);
      #1;
      cyc++;
      rst = 1'b0;
      check_reset_outputs("midrst");
      prev_stall = 1'b0;
      prev_done  = 1'b0;
      exp_q.delete();
      n_ren = 0;
      n_pop = 0;
      repeat (4) begin
         tick(1'b1);
         check("midrst_no_valid", out_valid, 0);
         check("midrst_no_ren",   ren_bw, 0);
      end
      run_frame(3, 2, 0, -1, 60);
      check("after_rst_done_t15", done_cyc - t_start, 15);

      // Random frames with random contents and random back-pressure.
      for (int it = 0; it < 5; it++) begin
         for (int y = 0; y < 16; y++)
            for (int x = 0; x < 16; x++)
               sram[y][x] = 8'($urandom);
         run_frame($urandom_range(0, 5), $urandom_range(0, 3), 1, -1, 400);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
